// File: rtl/space_inv_pkg.sv
// Shared types and screen constants for the space-invaders game blocks.
// Holds the fire-scheduler state encoding, the vertical screen bound used to
// saturate missile spawn positions, and the frame-tick edge-detect helper that
// every frame-paced block uses (input -> sync flop -> delay flop, pulse on 0->1).
package space_inv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COOLDOWN,
    SELECT,
    ISSUE,
    HALT
  } fire_state_t;

  localparam logic [9:0] SCREEN_Y_MAX = 10'd479;

  // One-cycle pulse on the rising edge seen between the two frame flops.
  function automatic logic frame_rise(input logic sync_q, input logic prev_q);
    return sync_q & ~prev_q;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), advances every clock.
// Ports: Clk, Reset_n (async active-low), seed (reset value, must be non-zero),
//        q (current LFSR state).
module lfsr16 (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic feedback_c;

  assign feedback_c = q[15] ^ q[13] ^ q[12] ^ q[10];

  // Maximal-length taps: a non-zero seed never reaches the all-zero state.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      q <= seed;
    end else begin
      q <= {q[14:0], feedback_c};
    end
  end

endmodule

// File: rtl/alien_fire_scheduler.sv
// Chooses which alien fires the next enemy missile and hands one request at a
// time to the missile launcher on a frame-paced pseudo-random cooldown.
// Ports:
//   Clk, Reset_n                 clock, async active-low reset
//   frame_clk                    vsync-rate tick (edge detected internally)
//   game_enable                  low forces IDLE (except from HALT)
//   alien_hit / alien_oob        per-alien dead / reached-bottom flags
//   alien_x_flat / alien_y_flat  per-alien centre, alien i at [i*10 +: 10]
//   slot_busy                    per-slot missile-in-flight flags
//   fire_ready                   launcher accepts the pending request
//   fire_valid, fire_slot, fire_x, fire_y, fire_src   fire request
//   wave_clear, invaded          sticky game-state flags
module alien_fire_scheduler
  import space_inv_pkg::*;
#(
  parameter int unsigned NUM_ALIENS    = 8,
  parameter int unsigned NUM_SLOTS     = 2,
  parameter logic [9:0]  COOLDOWN_MIN  = 10'd30,
  parameter int unsigned COOLDOWN_RAND = 4,
  parameter logic [9:0]  FIRE_Y_OFFSET = 10'd12,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  localparam int unsigned SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
  localparam int unsigned SRC_W  = (NUM_ALIENS > 1) ? $clog2(NUM_ALIENS) : 1
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    frame_clk,
  input  logic                    game_enable,
  input  logic [NUM_ALIENS-1:0]   alien_hit,
  input  logic [NUM_ALIENS-1:0]   alien_oob,
  input  logic [10*NUM_ALIENS-1:0] alien_x_flat,
  input  logic [10*NUM_ALIENS-1:0] alien_y_flat,
  input  logic [NUM_SLOTS-1:0]    slot_busy,
  input  logic                    fire_ready,
  output logic                    fire_valid,
  output logic [SLOT_W-1:0]       fire_slot,
  output logic [9:0]              fire_x,
  output logic [9:0]              fire_y,
  output logic [SRC_W-1:0]        fire_src,
  output logic                    wave_clear,
  output logic                    invaded
);

  localparam int unsigned CNT_W = SRC_W + 1;

  fire_state_t       state_q, state_d;
  logic [9:0]        cooldown_q, cooldown_d;
  logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0]  cand_q, cand_d;
  logic [CNT_W-1:0]  scanned_q, scanned_d;
  logic              fire_valid_q, fire_valid_d;
  logic [SLOT_W-1:0] fire_slot_q, fire_slot_d;
  logic [9:0]        fire_x_q, fire_x_d;
  logic [9:0]        fire_y_q, fire_y_d;
  logic [SRC_W-1:0]  fire_src_q, fire_src_d;
  logic              wave_clear_q, wave_clear_d;
  logic              invaded_q, invaded_d;
  logic              frame_s1_q, frame_s2_q;

  logic [15:0]       lfsr_q;
  logic              lfsr_unused_c;
  logic              frame_tick_c;
  logic [9:0]        cooldown_load_c;
  logic [SLOT_W-1:0] free_slot_c;
  logic              any_free_c;
  logic              all_hit_c;
  logic              invade_c;
  logic [10:0]       spawn_y_c;

  lfsr16 u_lfsr (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .seed    (LFSR_SEED),
    .q       (lfsr_q)
  );

  assign lfsr_unused_c   = ^lfsr_q[15:COOLDOWN_RAND];
  assign frame_tick_c    = frame_rise(frame_s1_q, frame_s2_q);
  assign cooldown_load_c = COOLDOWN_MIN + 10'(lfsr_q[COOLDOWN_RAND-1:0]);
  assign any_free_c      = ~&slot_busy;
  assign all_hit_c       = &alien_hit;
  assign invade_c        = |(alien_oob & ~alien_hit);
  // 11-bit sum so the offset cannot wrap before the saturation compare.
  assign spawn_y_c       = {1'b0, alien_y_flat[32'(cand_q)*10 +: 10]} + {1'b0, FIRE_Y_OFFSET};

  // Lowest-index free slot.
  always_comb begin
    free_slot_c = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!slot_busy[i]) free_slot_c = SLOT_W'(i);
    end
  end

  // Round-robin increment modulo NUM_ALIENS.
  function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] idx);
    return (32'(idx) == NUM_ALIENS - 1) ? '0 : idx + SRC_W'(1);
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    cooldown_d   = cooldown_q;
    rr_ptr_d     = rr_ptr_q;
    cand_d       = cand_q;
    scanned_d    = scanned_q;
    fire_valid_d = fire_valid_q;
    fire_slot_d  = fire_slot_q;
    fire_x_d     = fire_x_q;
    fire_y_d     = fire_y_q;
    fire_src_d   = fire_src_q;
    wave_clear_d = wave_clear_q;
    invaded_d    = invaded_q;

    case (state_q)
      IDLE: begin
        fire_valid_d = 1'b0;
        if (game_enable) begin
          cooldown_d = cooldown_load_c;
          state_d    = COOLDOWN;
        end
      end
      COOLDOWN: begin
        if (cooldown_q != 10'd0) begin
          if (frame_tick_c) cooldown_d = cooldown_q - 10'd1;
        end else if (any_free_c) begin
          cand_d    = rr_ptr_q;
          scanned_d = '0;
          state_d   = SELECT;
        end
      end
      SELECT: begin
        if (!alien_hit[cand_q]) begin
          fire_src_d   = cand_q;
          fire_x_d     = alien_x_flat[32'(cand_q)*10 +: 10];
          fire_y_d     = (spawn_y_c > {1'b0, SCREEN_Y_MAX}) ? SCREEN_Y_MAX : spawn_y_c[9:0];
          fire_slot_d  = free_slot_c;
          fire_valid_d = 1'b1;
          state_d      = ISSUE;
        end else if (scanned_q == CNT_W'(NUM_ALIENS - 1)) begin
          state_d = HALT;
        end else begin
          cand_d    = wrap_inc(cand_q);
          scanned_d = scanned_q + CNT_W'(1);
        end
      end
      ISSUE: begin
        // A handshake takes priority over an abort and swallows a coincident tick.
        if (fire_ready) begin
          fire_valid_d = 1'b0;
          rr_ptr_d     = wrap_inc(fire_src_q);
          cooldown_d   = cooldown_load_c;
          state_d      = COOLDOWN;
        end else if (alien_hit[fire_src_q]) begin
          fire_valid_d = 1'b0;
          cand_d       = rr_ptr_q;
          scanned_d    = '0;
          state_d      = SELECT;
        end
      end
      HALT: begin
        fire_valid_d = 1'b0;
      end
      default: begin
        fire_valid_d = 1'b0;
        state_d      = IDLE;
      end
    endcase

    if (!game_enable && state_q != HALT) begin
      fire_valid_d = 1'b0;
      state_d      = IDLE;
    end

    // Invasion outranks wave-clear when both appear on the same cycle.
    if (invade_c) begin
      invaded_d    = 1'b1;
      fire_valid_d = 1'b0;
      state_d      = HALT;
    end else if (all_hit_c) begin
      wave_clear_d = 1'b1;
      fire_valid_d = 1'b0;
      state_d      = HALT;
    end
  end

  // State and output registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      cooldown_q   <= '0;
      rr_ptr_q     <= '0;
      cand_q       <= '0;
      scanned_q    <= '0;
      fire_valid_q <= 1'b0;
      fire_slot_q  <= '0;
      fire_x_q     <= '0;
      fire_y_q     <= '0;
      fire_src_q   <= '0;
      wave_clear_q <= 1'b0;
      invaded_q    <= 1'b0;
      frame_s1_q   <= 1'b0;
      frame_s2_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cooldown_q   <= cooldown_d;
      rr_ptr_q     <= rr_ptr_d;
      cand_q       <= cand_d;
      scanned_q    <= scanned_d;
      fire_valid_q <= fire_valid_d;
      fire_slot_q  <= fire_slot_d;
      fire_x_q     <= fire_x_d;
      fire_y_q     <= fire_y_d;
      fire_src_q   <= fire_src_d;
      wave_clear_q <= wave_clear_d;
      invaded_q    <= invaded_d;
      frame_s1_q   <= frame_clk;
      frame_s2_q   <= frame_s1_q;
    end
  end

  assign fire_valid = fire_valid_q;
  assign fire_slot  = fire_slot_q;
  assign fire_x     = fire_x_q;
  assign fire_y     = fire_y_q;
  assign fire_src   = fire_src_q;
  assign wave_clear = wave_clear_q;
  assign invaded    = invaded_q;

endmodule

// File: tb/tb_alien_fire_scheduler.sv
// Directed self-checking bench for alien_fire_scheduler.
// Frame ticks are 16 clocks apart (8 high, 8 low); alien i sits at
// x = 100 + 20*i, y = 50 + 10*i unless a scenario moves it.
module tb_alien_fire_scheduler;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        frame_clk;
  logic        game_enable;
  logic [7:0]  alien_hit;
  logic [7:0]  alien_oob;
  logic [79:0] alien_x_flat;
  logic [79:0] alien_y_flat;
  logic [1:0]  slot_busy;
  logic        fire_ready;
  logic        fire_valid;
  logic [0:0]  fire_slot;
  logic [9:0]  fire_x;
  logic [9:0]  fire_y;
  logic [2:0]  fire_src;
  logic        wave_clear;
  logic        invaded;

  int errors = 0;
  int checks = 0;

  alien_fire_scheduler dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .frame_clk    (frame_clk),
    .game_enable  (game_enable),
    .alien_hit    (alien_hit),
    .alien_oob    (alien_oob),
    .alien_x_flat (alien_x_flat),
    .alien_y_flat (alien_y_flat),
    .slot_busy    (slot_busy),
    .fire_ready   (fire_ready),
    .fire_valid   (fire_valid),
    .fire_slot    (fire_slot),
    .fire_x       (fire_x),
    .fire_y       (fire_y),
    .fire_src     (fire_src),
    .wave_clear   (wave_clear),
    .invaded      (invaded)
  );

  always #5 Clk = ~Clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic apply_reset();
    Reset_n     = 1'b0;
    frame_clk   = 1'b0;
    game_enable = 1'b0;
    fire_ready  = 1'b0;
    alien_hit   = '0;
    alien_oob   = '0;
    slot_busy   = '0;
    for (int i = 0; i < 8; i++) begin
      alien_x_flat[i*10 +: 10] = 10'(100 + 20 * i);
      alien_y_flat[i*10 +: 10] = 10'(50 + 10 * i);
    end
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
  endtask

  // Generates frame ticks until fire_valid is seen or max_ticks elapse.
  // lat = clocks after the rising frame_clk of the last tick.
  task automatic wait_shot(input int max_ticks, output bit got, output int ticks,
                           output int lat, output logic [2:0] src,
                           output logic [9:0] x, output logic [9:0] y,
                           output logic [0:0] slot);
    got = 1'b0; ticks = 0; lat = 0; src = '0; x = '0; y = '0; slot = '0;
    for (int t = 1; t <= max_ticks && !got; t++) begin
      frame_clk = 1'b1;
      for (int c = 1; c <= 16 && !got; c++) begin
        if (c == 9) frame_clk = 1'b0;
        @(negedge Clk);
        if (fire_valid === 1'b1) begin
          got = 1'b1; ticks = t; lat = c;
          src = fire_src; x = fire_x; y = fire_y; slot = fire_slot;
        end
      end
    end
    frame_clk = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    @(negedge Clk);
    checks++;
    if ({fire_valid, fire_slot, fire_x, fire_y, fire_src, wave_clear, invaded} !== 26'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0",
               {fire_valid, fire_slot, fire_x, fire_y, fire_src, wave_clear, invaded});
    end
    apply_reset();
    repeat (3) @(negedge Clk);
    checks++;
    if (fire_valid !== 1'b0) begin
      errors++; $display("FAIL reset_disabled_valid got=%b exp=0", fire_valid);
    end
  endtask

  task automatic test_round_robin();
    bit got; int ticks, lat; logic [2:0] src; logic [9:0] x, y; logic [0:0] slot;
    apply_reset();
    fire_ready  = 1'b1;
    game_enable = 1'b1;
    for (int s = 0; s < 9; s++) begin
      wait_shot(60, got, ticks, lat, src, x, y, slot);
      checks++;
      if (!got) begin
        errors++; $display("FAIL rr_timeout shot=%0d no fire_valid within 60 ticks", s);
      end else begin
        checks++;
        if (src !== 3'(s % 8) || x !== 10'(100 + 20 * (s % 8)) ||
            y !== 10'(62 + 10 * (s % 8)) || slot !== 1'b0) begin
          errors++;
          $display("FAIL rr_request shot=%0d got src=%0d x=%0d y=%0d slot=%0d exp src=%0d x=%0d y=%0d slot=0",
                   s, src, x, y, slot, s % 8, 100 + 20 * (s % 8), 62 + 10 * (s % 8));
        end
        checks++;
        if (ticks < 30 || ticks > 45) begin
          errors++; $display("FAIL rr_cooldown shot=%0d got=%0d ticks exp=30..45", s, ticks);
        end
        checks++;
        if (lat != 4) begin
          errors++; $display("FAIL rr_latency shot=%0d got=%0d exp=4", s, lat);
        end
      end
    end
  endtask

  task automatic test_skip_dead();
    bit got; int ticks, lat; logic [2:0] src; logic [9:0] x, y; logic [0:0] slot;
    apply_reset();
    alien_hit                = 8'b0000_0111;
    alien_y_flat[30 +: 10]   = 10'd470;
    fire_ready               = 1'b1;
    game_enable              = 1'b1;
    wait_shot(60, got, ticks, lat, src, x, y, slot);
    checks++;
    if (!got) begin
      errors++; $display("FAIL skip_timeout no fire_valid within 60 ticks");
    end else begin
      checks++;
      if (src !== 3'd3 || x !== 10'd160) begin
        errors++; $display("FAIL skip_src got src=%0d x=%0d exp src=3 x=160", src, x);
      end
      checks++;
      if (y !== 10'd479) begin
        errors++; $display("FAIL skip_y_saturate got=%0d exp=479", y);
      end
      checks++;
      if (lat != 7) begin
        errors++; $display("FAIL skip_latency got=%0d exp=7", lat);
      end
    end
  endtask

  task automatic test_slots_busy();
    bit got; int ticks, lat; logic [2:0] src; logic [9:0] x, y; logic [0:0] slot;
    apply_reset();
    slot_busy   = 2'b11;
    game_enable = 1'b1;
    wait_shot(50, got, ticks, lat, src, x, y, slot);
    checks++;
    if (got) begin
      errors++; $display("FAIL busy_no_valid got valid after %0d ticks exp none", ticks);
    end
    slot_busy = 2'b01;
    @(negedge Clk);
    checks++;
    if (fire_valid !== 1'b0) begin
      errors++; $display("FAIL busy_release_early got=%b exp=0", fire_valid);
    end
    @(negedge Clk);
    checks++;
    if (fire_valid !== 1'b1 || fire_slot !== 1'b1) begin
      errors++; $display("FAIL busy_release got valid=%b slot=%0d exp valid=1 slot=1", fire_valid, fire_slot);
    end
    slot_busy = 2'b11;
    for (int c = 0; c < 5; c++) begin
      @(negedge Clk);
      checks++;
      if ({fire_valid, fire_slot, fire_src, fire_x, fire_y} !== {1'b1, 1'b1, 3'd0, 10'd100, 10'd62}) begin
        errors++;
        $display("FAIL busy_hold cycle=%0d got valid=%b slot=%0d src=%0d x=%0d y=%0d exp 1 1 0 100 62",
                 c, fire_valid, fire_slot, fire_src, fire_x, fire_y);
      end
    end
    fire_ready = 1'b1;
    @(negedge Clk);
    fire_ready = 1'b0;
    checks++;
    if (fire_valid !== 1'b0) begin
      errors++; $display("FAIL busy_handshake_drop got=%b exp=0", fire_valid);
    end
  endtask

  task automatic test_abort_and_halt();
    bit got; int ticks, lat; logic [2:0] src; logic [9:0] x, y; logic [0:0] slot;
    apply_reset();
    game_enable = 1'b1;
    wait_shot(60, got, ticks, lat, src, x, y, slot);
    checks++;
    if (!got || src !== 3'd0) begin
      errors++; $display("FAIL abort_setup got got=%b src=%0d exp got=1 src=0", got, src);
    end
    alien_hit = 8'h01;
    @(negedge Clk);
    checks++;
    if (fire_valid !== 1'b0) begin
      errors++; $display("FAIL abort_drop got=%b exp=0", fire_valid);
    end
    repeat (2) @(negedge Clk);
    checks++;
    if (fire_valid !== 1'b1 || fire_src !== 3'd1 || fire_x !== 10'd120) begin
      errors++; $display("FAIL abort_reselect got valid=%b src=%0d x=%0d exp 1 1 120", fire_valid, fire_src, fire_x);
    end
    // Everyone dies while a request is pending.
    alien_hit = 8'hFF;
    @(negedge Clk);
    checks++;
    if (wave_clear !== 1'b1 || invaded !== 1'b0 || fire_valid !== 1'b0) begin
      errors++; $display("FAIL wave_clear got wc=%b inv=%b valid=%b exp 1 0 0", wave_clear, invaded, fire_valid);
    end
    wait_shot(3, got, ticks, lat, src, x, y, slot);
    checks++;
    if (got) begin
      errors++; $display("FAIL halt_no_valid got valid exp none");
    end
    // Invasion on the same cycle as another alien's hit.
    apply_reset();
    alien_hit   = 8'h3F;
    game_enable = 1'b1;
    repeat (3) @(negedge Clk);
    alien_oob = 8'h01;
    repeat (2) @(negedge Clk);
    checks++;
    if (invaded !== 1'b0) begin
      errors++; $display("FAIL oob_dead_ignored got=%b exp=0", invaded);
    end
    alien_hit = 8'h7F;
    alien_oob = 8'h81;
    @(negedge Clk);
    checks++;
    if (invaded !== 1'b1 || wave_clear !== 1'b0 || fire_valid !== 1'b0) begin
      errors++; $display("FAIL invaded got inv=%b wc=%b valid=%b exp 1 0 0", invaded, wave_clear, fire_valid);
    end
    repeat (5) @(negedge Clk);
    checks++;
    if (invaded !== 1'b1 || wave_clear !== 1'b0) begin
      errors++; $display("FAIL invaded_sticky got inv=%b wc=%b exp 1 0", invaded, wave_clear);
    end
  endtask

  task automatic test_async_reset_and_enable();
    bit got; int ticks, lat; logic [2:0] src; logic [9:0] x, y; logic [0:0] slot;
    apply_reset();
    game_enable = 1'b1;
    wait_shot(60, got, ticks, lat, src, x, y, slot);
    #2 Reset_n = 1'b0;
    #1;
    checks++;
    if ({fire_valid, fire_slot, fire_x, fire_y, fire_src, wave_clear, invaded} !== 26'd0) begin
      errors++;
      $display("FAIL async_reset got valid=%b x=%0d y=%0d src=%0d exp all zero", fire_valid, fire_x, fire_y, fire_src);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    wait_shot(60, got, ticks, lat, src, x, y, slot);
    fire_ready = 1'b1;
    @(negedge Clk);
    fire_ready = 1'b0;
    wait_shot(60, got, ticks, lat, src, x, y, slot);
    checks++;
    if (!got || src !== 3'd1) begin
      errors++; $display("FAIL enable_setup got got=%b src=%0d exp got=1 src=1", got, src);
    end
    game_enable = 1'b0;
    @(negedge Clk);
    checks++;
    if (fire_valid !== 1'b0) begin
      errors++; $display("FAIL disable_drop got=%b exp=0", fire_valid);
    end
    repeat (3) @(negedge Clk);
    game_enable = 1'b1;
    wait_shot(60, got, ticks, lat, src, x, y, slot);
    checks++;
    if (!got || src !== 3'd1) begin
      errors++; $display("FAIL enable_rr_kept got got=%b src=%0d exp got=1 src=1", got, src);
    end
  endtask

  initial begin
    Reset_n     = 1'b0;
    frame_clk   = 1'b0;
    game_enable = 1'b0;
    fire_ready  = 1'b0;
    alien_hit   = '0;
    alien_oob   = '0;
    slot_busy   = '0;
    alien_x_flat = '0;
    alien_y_flat = '0;
    test_reset();
    test_round_robin();
    test_skip_dead();
    test_slots_busy();
    test_abort_and_halt();
    test_async_reset_and_enable();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
